core_tlb_maint: RTL and testbench

Owns the TLB entry array and performs every state-changing or readback operation on it: TLBRD, TLBWR, TLBFILL and INVTLB. It is the writer/maintenance side of the TLB; its entries_o bus drives the entries_i input of every core_tlb_lookup instance (fetch and memory side). Requests come from the CSR/privileged-instruction unit in the execute stage over a valid/ready handshake. INVTLB is a multi-cycle sweep, one entry per cycle, so the compare logic stays off the lookup critical path.

---
 rtl/core_tlb_maint.sv | 174 +++++++++++++++++
 tb/tb_core_tlb_maint.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_tlb_maint.sv
// TLB entry storage plus its maintenance engine: TLBRD/TLBWR/TLBFILL and the INVTLB sweep.
// entries_o feeds every lookup port straight from the flops.
package core_tlb_pkg;
    typedef struct packed {
        logic [18:0] vppn;
        logic [5:0]  ps;
        logic        g;
        logic [9:0]  asid;
        logic        e;
    } tlb_key_t;

    // data carries the even/odd physical translation pair; opaque to this block
    typedef struct packed {
        tlb_key_t    key;
        logic [47:0] data;
    } tlb_entry_t;
endpackage

module core_tlb_maint
    import core_tlb_pkg::*;
#(
    parameter int unsigned TLB_ENTRY_NUM       = 32,
    parameter bit          TLB_SUPPORT_4M_PAGE = 1'b0,
    localparam int unsigned IdxW               = $clog2(TLB_ENTRY_NUM)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                req_valid_i,
    output logic                                req_ready_o,
    input  logic [1:0]                          req_op_i,
    input  logic [IdxW-1:0]                     req_index_i,
    input  tlb_entry_t                          req_entry_i,
    input  logic [4:0]                          inv_op_i,
    input  logic [9:0]                          inv_asid_i,
    input  logic [18:0]                         inv_vppn_i,
    output logic                                resp_valid_o,
    output logic [IdxW-1:0]                     resp_index_o,
    output tlb_entry_t                          resp_entry_o,
    output logic                                resp_err_o,
    output tlb_entry_t [TLB_ENTRY_NUM-1:0]      entries_o
);

    localparam logic [1:0] OpRead  = 2'd0;
    localparam logic [1:0] OpWrite = 2'd1;
    localparam logic [1:0] OpFill  = 2'd2;

    typedef enum logic [1:0] {StIdle, StSweep, StDone} state_e;

    state_e                           state_q;
    tlb_entry_t [TLB_ENTRY_NUM-1:0]   entries_q;
    logic [IdxW-1:0]                  fill_q;
    logic [IdxW-1:0]                  sweep_q;
    logic [4:0]                       inv_op_q;
    logic [9:0]                       inv_asid_q;
    logic [18:0]                      inv_vppn_q;
    logic                             ready_q;
    logic                             resp_valid_q;
    logic                             resp_err_q;
    logic [IdxW-1:0]                  resp_index_q;
    tlb_entry_t                       resp_entry_q;

    tlb_entry_t cur;
    logic       va_hit;
    logic       asid_hit;
    logic       inv_hit;

    // Match condition for the entry under the sweep pointer
    always_comb begin
        cur      = entries_q[sweep_q];
        asid_hit = (cur.key.asid == inv_asid_q);
        if (TLB_SUPPORT_4M_PAGE && (cur.key.ps == 6'd22)) begin
            va_hit = (cur.key.vppn[18:10] == inv_vppn_q[18:10]);
        end else begin
            va_hit = (cur.key.vppn == inv_vppn_q);
        end
        inv_hit = 1'b0;
        case (inv_op_q)
            5'd0, 5'd1: inv_hit = 1'b1;
            5'd2:       inv_hit = cur.key.g;
            5'd3:       inv_hit = !cur.key.g;
            5'd4:       inv_hit = !cur.key.g && asid_hit;
            5'd5:       inv_hit = !cur.key.g && asid_hit && va_hit;
            5'd6:       inv_hit = (cur.key.g || asid_hit) && va_hit;
            default:    inv_hit = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            entries_q    <= '0;
            fill_q       <= '0;
            sweep_q      <= '0;
            inv_op_q     <= '0;
            inv_asid_q   <= '0;
            inv_vppn_q   <= '0;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_index_q <= '0;
            resp_entry_q <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_index_q <= '0;
            resp_entry_q <= '0;
            case (state_q)
                StIdle: begin
                    if (req_valid_i && ready_q) begin
                        case (req_op_i)
                            OpRead: begin
                                resp_valid_q <= 1'b1;
                                resp_index_q <= req_index_i;
                                resp_entry_q <= entries_q[req_index_i];
                            end
                            OpWrite: begin
                                entries_q[req_index_i] <= req_entry_i;
                                resp_valid_q           <= 1'b1;
                                resp_index_q           <= req_index_i;
                            end
                            OpFill: begin
                                entries_q[fill_q] <= req_entry_i;
                                resp_valid_q      <= 1'b1;
                                resp_index_q      <= fill_q;
                                fill_q            <= fill_q + 1'b1;
                            end
                            default: begin
                                inv_op_q   <= inv_op_i;
                                inv_asid_q <= inv_asid_i;
                                inv_vppn_q <= inv_vppn_i;
                                sweep_q    <= '0;
                                ready_q    <= 1'b0;
                                if (inv_op_i > 5'd6) begin
                                    // Unsupported op: report at once, touch nothing
                                    state_q      <= StDone;
                                    resp_valid_q <= 1'b1;
                                    resp_err_q   <= 1'b1;
                                end else begin
                                    state_q <= StSweep;
                                end
                            end
                        endcase
                    end
                end
                StSweep: begin
                    if (inv_hit) begin
                        entries_q[sweep_q].key.e <= 1'b0;
                    end
                    sweep_q <= sweep_q + 1'b1;
                    if (sweep_q == IdxW'(TLB_ENTRY_NUM - 1)) begin
                        state_q      <= StDone;
                        resp_valid_q <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= StIdle;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready_o  = ready_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_err_o   = resp_err_q;
    assign resp_index_o = resp_index_q;
    assign resp_entry_o = resp_entry_q;
    assign entries_o    = entries_q;

endmodule

// File: tb/tb_core_tlb_maint.sv
// Bench for core_tlb_maint: one instance per page-size mode, directed table,
// hand-written multi-cycle sequences and random ops against an array model.
module tb_core_tlb_maint;
    import core_tlb_pkg::*;

    localparam int N = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             req_valid;
    logic [1:0]       req_op;
    logic [4:0]       req_index;
    tlb_entry_t       req_entry;
    logic [4:0]       inv_op;
    logic [9:0]       inv_asid;
    logic [18:0]      inv_vppn;

    logic             rdy0, rdy1, rv0, rv1, rerr0, rerr1;
    logic [4:0]       ri0, ri1;
    tlb_entry_t       re0, re1;
    tlb_entry_t [N-1:0] ents0, ents1;

    core_tlb_maint #(.TLB_ENTRY_NUM(N), .TLB_SUPPORT_4M_PAGE(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_ready_o(rdy0),
        .req_op_i(req_op), .req_index_i(req_index), .req_entry_i(req_entry),
        .inv_op_i(inv_op), .inv_asid_i(inv_asid), .inv_vppn_i(inv_vppn),
        .resp_valid_o(rv0), .resp_index_o(ri0), .resp_entry_o(re0), .resp_err_o(rerr0),
        .entries_o(ents0)
    );

    core_tlb_maint #(.TLB_ENTRY_NUM(N), .TLB_SUPPORT_4M_PAGE(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_ready_o(rdy1),
        .req_op_i(req_op), .req_index_i(req_index), .req_entry_i(req_entry),
        .inv_op_i(inv_op), .inv_asid_i(inv_asid), .inv_vppn_i(inv_vppn),
        .resp_valid_o(rv1), .resp_index_o(ri1), .resp_entry_o(re1), .resp_err_o(rerr1),
        .entries_o(ents1)
    );

    // Reference model: m0 = full-VA compare, m1 = 4M-page aware
    tlb_entry_t m0 [N];
    tlb_entry_t m1 [N];
    int         fill_ptr;
    int         n_checks = 0;
    int         n_fail = 0;

    int         g_lat, g_nrdy;
    logic       g_v1, g_err0, g_err1;
    logic [4:0] g_idx0, g_idx1;
    tlb_entry_t g_ent0, g_ent1;

    logic [18:0] vpool [4];
    logic [9:0]  apool [3];

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [4:0]  idx;
        tlb_entry_t  ent;
        logic [4:0]  iop;
        logic [9:0]  asid;
        logic [18:0] vppn;
        logic [4:0]  exp_idx;
        logic        exp_err;
        tlb_entry_t  exp_ent;
    } vec_t;

    vec_t tab [12];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic check_entries(input string name);
        int bad0 = 0;
        int bad1 = 0;
        for (int i = 0; i < N; i++) begin
            if (ents0[i] !== m0[i]) bad0++;
            if (ents1[i] !== m1[i]) bad1++;
        end
        check({name, " entries0 mismatching"}, 128'(bad0), 128'(0));
        check({name, " entries1 mismatching"}, 128'(bad1), 128'(0));
    endtask

    function automatic bit inv_match(input tlb_entry_t en, input logic [4:0] op,
                                     input logic [9:0] asid, input logic [18:0] vppn,
                                     input bit big);
        bit g = en.key.g;
        bit a = (en.key.asid == asid);
        bit v = (big && en.key.ps == 6'd22) ? (en.key.vppn[18:10] == vppn[18:10])
                                            : (en.key.vppn == vppn);
        case (op)
            5'd0, 5'd1: return 1'b1;
            5'd2:       return g;
            5'd3:       return !g;
            5'd4:       return !g && a;
            5'd5:       return !g && a && v;
            5'd6:       return (g || a) && v;
            default:    return 1'b0;
        endcase
    endfunction

    task automatic model_apply(input logic [1:0] op, input logic [4:0] idx, input tlb_entry_t ent,
                               input logic [4:0] iop, input logic [9:0] asid,
                               input logic [18:0] vppn);
        case (op)
            2'd1: begin m0[idx] = ent; m1[idx] = ent; end
            2'd2: begin m0[fill_ptr] = ent; m1[fill_ptr] = ent; fill_ptr = (fill_ptr + 1) % N; end
            2'd3: begin
                for (int i = 0; i < N; i++) begin
                    if (inv_match(m0[i], iop, asid, vppn, 1'b0)) m0[i].key.e = 1'b0;
                    if (inv_match(m1[i], iop, asid, vppn, 1'b1)) m1[i].key.e = 1'b0;
                end
            end
            default: ;
        endcase
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin m0[i] = '0; m1[i] = '0; end
        fill_ptr = 0;
    endtask

    // Issue one request and wait (bounded) for its response
    task automatic apply(input logic [1:0] op, input logic [4:0] idx, input tlb_entry_t ent,
                         input logic [4:0] iop, input logic [9:0] asid, input logic [18:0] vppn);
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = op; req_index = idx; req_entry = ent;
        inv_op = iop; inv_asid = asid; inv_vppn = vppn;
        @(posedge clk); #1;
        req_valid = 1'b0;
        g_lat = 0; g_nrdy = 0;
        do begin
            @(negedge clk);
            g_lat++;
            if (!rdy0) g_nrdy++;
        end while (!rv0 && g_lat < 100);
        g_v1 = rv1; g_idx0 = ri0; g_idx1 = ri1; g_ent0 = re0; g_ent1 = re1;
        g_err0 = rerr0; g_err1 = rerr1;
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [4:0] idx,
                          input tlb_entry_t ent, input logic [4:0] iop, input logic [9:0] asid,
                          input logic [18:0] vppn, input logic [4:0] exp_idx, input logic exp_err,
                          input tlb_entry_t exp_ent0, input tlb_entry_t exp_ent1);
        int exp_lat = (op == 2'd3 && iop <= 5'd6) ? N + 1 : 1;
        int exp_nrdy = (op == 2'd3) ? exp_lat : 0;
        apply(op, idx, ent, iop, asid, vppn);
        check({name, " latency"}, 128'(g_lat), 128'(exp_lat));
        check({name, " ready-low cycles"}, 128'(g_nrdy), 128'(exp_nrdy));
        check({name, " valid1"}, 128'(g_v1), 128'(1));
        check({name, " index0"}, 128'(g_idx0), 128'(exp_idx));
        check({name, " index1"}, 128'(g_idx1), 128'(exp_idx));
        check({name, " err0"}, 128'(g_err0), 128'(exp_err));
        check({name, " err1"}, 128'(g_err1), 128'(exp_err));
        check({name, " entry0"}, 128'(g_ent0), 128'(exp_ent0));
        check({name, " entry1"}, 128'(g_ent1), 128'(exp_ent1));
        model_apply(op, idx, ent, iop, asid, vppn);
        check_entries(name);
    endtask

    function automatic tlb_entry_t rand_entry();
        tlb_entry_t r;
        r.key.vppn = vpool[$urandom_range(0, 3)];
        r.key.ps   = ($urandom_range(0, 1) == 1) ? 6'd22 : 6'd12;
        r.key.g    = 1'($urandom_range(0, 1));
        r.key.asid = apool[$urandom_range(0, 2)];
        r.key.e    = ($urandom_range(0, 3) != 0);
        r.data     = 48'({$urandom(), $urandom()});
        return r;
    endfunction

    function automatic tlb_entry_t mk(input logic [18:0] vppn, input logic [5:0] ps, input logic g,
                                      input logic [9:0] asid, input logic e,
                                      input logic [47:0] data);
        tlb_entry_t r;
        r.key.vppn = vppn; r.key.ps = ps; r.key.g = g; r.key.asid = asid; r.key.e = e;
        r.data = data;
        return r;
    endfunction

    task automatic do_reset();
        #1 rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tlb_entry_t ea, eb, ec, ebx, z, e;
        logic [18:0] va;
        logic [1:0] op;
        logic [4:0] idx, iop;
        logic [9:0] asid;
        logic [18:0] vppn;
        int seen;

        vpool[0] = 19'h12345; vpool[1] = 19'h7FC00; vpool[2] = 19'h7FDFF; vpool[3] = 19'h00001;
        apool[0] = 10'd5; apool[1] = 10'd6; apool[2] = 10'h2A;
        req_valid = 1'b0; req_op = '0; req_index = '0; req_entry = '0;
        inv_op = '0; inv_asid = '0; inv_vppn = '0;
        z = '0;

        ea  = mk(19'h12345, 6'd12, 1'b0, 10'h2A, 1'b1, 48'h0123_4567_89AB);
        eb  = mk(19'h00001, 6'd12, 1'b1, 10'h006, 1'b1, 48'hAAAA_5555_0F0F);
        ec  = mk(19'h00002, 6'd12, 1'b0, 10'h005, 1'b1, 48'h1111_2222_3333);
        ebx = eb; ebx.key.e = 1'b0;

        tab[0]  = '{"rd5_reset",     2'd0, 5'd5, z,  5'd0, 10'd0, 19'd0, 5'd5, 1'b0, z};
        tab[1]  = '{"wr3",           2'd1, 5'd3, ea, 5'd0, 10'd0, 19'd0, 5'd3, 1'b0, z};
        tab[2]  = '{"rd3",           2'd0, 5'd3, z,  5'd0, 10'd0, 19'd0, 5'd3, 1'b0, ea};
        tab[3]  = '{"fill_b",        2'd2, 5'd9, eb, 5'd0, 10'd0, 19'd0, 5'd0, 1'b0, z};
        tab[4]  = '{"fill_c",        2'd2, 5'd9, ec, 5'd0, 10'd0, 19'd0, 5'd1, 1'b0, z};
        tab[5]  = '{"rd0",           2'd0, 5'd0, z,  5'd0, 10'd0, 19'd0, 5'd0, 1'b0, eb};
        tab[6]  = '{"inv_op7",       2'd3, 5'd0, z,  5'd7, 10'd5, 19'd0, 5'd0, 1'b1, z};
        tab[7]  = '{"rd1_after_err", 2'd0, 5'd1, z,  5'd0, 10'd0, 19'd0, 5'd1, 1'b0, ec};
        tab[8]  = '{"inv_op2",       2'd3, 5'd0, z,  5'd2, 10'd0, 19'd0, 5'd0, 1'b0, z};
        tab[9]  = '{"rd0_g_cleared", 2'd0, 5'd0, z,  5'd0, 10'd0, 19'd0, 5'd0, 1'b0, ebx};
        tab[10] = '{"rd1_kept",      2'd0, 5'd1, z,  5'd0, 10'd0, 19'd0, 5'd1, 1'b0, ec};
        tab[11] = '{"rd3_kept",      2'd0, 5'd3, z,  5'd0, 10'd0, 19'd0, 5'd3, 1'b0, ea};

        do_reset();
        @(negedge clk);
        check("reset ready0", 128'(rdy0), 128'(1));
        check("reset ready1", 128'(rdy1), 128'(1));
        check("reset resp_valid", 128'(rv0), 128'(0));
        check("reset resp_err", 128'(rerr0), 128'(0));
        check("reset resp_index", 128'(ri0), 128'(0));
        check("reset resp_entry", 128'(re0), 128'(0));
        check_entries("reset");

        for (int i = 0; i < 12; i++) begin
            run_op(tab[i].name, tab[i].op, tab[i].idx, tab[i].ent, tab[i].iop, tab[i].asid,
                   tab[i].vppn, tab[i].exp_idx, tab[i].exp_err, tab[i].exp_ent, tab[i].exp_ent);
        end

        // INV op 5 hits only the non-global entry with matching ASID and VA
        va = 19'h0ABCD;
        run_op("inv_all", 2'd3, 5'd0, z, 5'd0, 10'd0, 19'd0, 5'd0, 1'b0, z, z);
        run_op("ld0", 2'd1, 5'd0, mk(va, 6'd12, 1'b1, 10'd5, 1'b1, 48'h1), 5'd0, 10'd0, 19'd0,
               5'd0, 1'b0, z, z);
        run_op("ld1", 2'd1, 5'd1, mk(va, 6'd12, 1'b0, 10'd5, 1'b1, 48'h2), 5'd0, 10'd0, 19'd0,
               5'd1, 1'b0, z, z);
        run_op("ld2", 2'd1, 5'd2, mk(va, 6'd12, 1'b0, 10'd6, 1'b1, 48'h3), 5'd0, 10'd0, 19'd0,
               5'd2, 1'b0, z, z);
        run_op("inv_op5", 2'd3, 5'd0, z, 5'd5, 10'd5, va, 5'd0, 1'b0, z, z);
        check("inv_op5 idx0 e", 128'(ents0[0].key.e), 128'(1));
        check("inv_op5 idx1 e", 128'(ents0[1].key.e), 128'(0));
        check("inv_op5 idx2 e", 128'(ents0[2].key.e), 128'(1));

        // 4M page: upper nine vppn bits match only in the 4M-aware instance
        run_op("ld4m", 2'd1, 5'd4, mk(19'h7FC00, 6'd22, 1'b1, 10'd0, 1'b1, 48'h4), 5'd0, 10'd0,
               19'd0, 5'd4, 1'b0, z, z);
        run_op("inv_op6_4m", 2'd3, 5'd0, z, 5'd6, 10'd0, 19'h7FDFF, 5'd0, 1'b0, z, z);
        check("4m full-compare e kept", 128'(ents0[4].key.e), 128'(1));
        check("4m aware e cleared", 128'(ents1[4].key.e), 128'(0));

        // Reset in the middle of a sweep: everything cleared, no response
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = 2'd3; inv_op = 5'd0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        check_entries("midsweep reset");
        check("midsweep reset resp_valid", 128'(rv0 | rv1), 128'(0));
        @(posedge clk); #1 rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rv0 || rv1) seen++;
        end
        check("midsweep no response", 128'(seen), 128'(0));
        check("midsweep ready after reset", 128'(rdy0 & rdy1), 128'(1));

        // 33 back-to-back fills: index wraps, ready never drops
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = 2'd2; req_entry = rand_entry();
        for (int i = 0; i <= N; i++) begin
            int exp_i;
            @(posedge clk);
            exp_i = fill_ptr;
            model_apply(2'd2, 5'd0, req_entry, 5'd0, 10'd0, 19'd0);
            #1;
            if (i < N) req_entry = rand_entry();
            else req_valid = 1'b0;
            @(negedge clk);
            check($sformatf("fill burst %0d valid", i), 128'(rv0 & rv1), 128'(1));
            check($sformatf("fill burst %0d index", i), 128'(ri0), 128'(exp_i));
            check($sformatf("fill burst %0d ready", i), 128'(rdy0), 128'(1));
        end
        check("fill burst last index", 128'(ri1), 128'(0));
        check_entries("fill burst");

        // Random ops against the model
        for (int k = 0; k < 80; k++) begin
            logic [4:0] exp_idx;
            tlb_entry_t x0, x1;
            op   = 2'($urandom_range(0, 3));
            idx  = 5'($urandom_range(0, N - 1));
            e    = rand_entry();
            iop  = 5'($urandom_range(0, 8));
            asid = apool[$urandom_range(0, 2)];
            vppn = vpool[$urandom_range(0, 3)];
            exp_idx = (op == 2'd0 || op == 2'd1) ? idx : (op == 2'd2) ? 5'(fill_ptr) : 5'd0;
            x0 = (op == 2'd0) ? m0[idx] : z;
            x1 = (op == 2'd0) ? m1[idx] : z;
            run_op($sformatf("rand%0d op%0d", k, op), op, idx, e, iop, asid, vppn, exp_idx,
                   (op == 2'd3 && iop > 5'd6), x0, x1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
